// File: rtl/opl3_timers.sv
// ============================================================================
//  Module   : opl3_timers
//  Purpose  : OPL3 Timer 1 (80 us) and Timer 2 (prescaled) with status/IRQ.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module opl3_timers #(
  parameter int TIMER2_PRESCALE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_80us,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] status,
  output logic       irq_n
);

  localparam int PW = $clog2(TIMER2_PRESCALE);
  localparam logic [PW-1:0] P_LAST = PW'(TIMER2_PRESCALE - 1);

  logic [7:0]    t1p_q, t1p_d, t2p_q, t2p_d;
  logic [7:0]    c1_q, c1_d, c2_q, c2_d;
  logic          st1_q, st1_d, st2_q, st2_d;
  logic          mt1_q, mt1_d, mt2_q, mt2_d;
  logic          ft1_q, ft1_d, ft2_q, ft2_d;
  logic [PW-1:0] p_q, p_d;
  logic          irq_n_q;

  logic w_wr_t1p, w_wr_t2p, w_wr_ctl, w_wr_rst;
  logic w_t2_tick, w_ovf1, w_ovf2;
  logic w_unused;

  assign w_wr_t1p  = wr_en && (wr_addr == 8'h02);
  assign w_wr_t2p  = wr_en && (wr_addr == 8'h03);
  assign w_wr_ctl  = wr_en && (wr_addr == 8'h04) && !wr_data[7];
  assign w_wr_rst  = wr_en && (wr_addr == 8'h04) &&  wr_data[7];
  assign w_t2_tick = tick_80us && (p_q == P_LAST);
  assign w_unused  = ^wr_data[4:2];

  always_comb begin
    t1p_d  = t1p_q;
    t2p_d  = t2p_q;
    c1_d   = c1_q;
    c2_d   = c2_q;
    st1_d  = st1_q;
    st2_d  = st2_q;
    mt1_d  = mt1_q;
    mt2_d  = mt2_q;
    ft1_d  = ft1_q;
    ft2_d  = ft2_q;
    p_d    = p_q;
    w_ovf1 = 1'b0;
    w_ovf2 = 1'b0;

    if (w_wr_t1p) t1p_d = wr_data;
    if (w_wr_t2p) t2p_d = wr_data;
    if (w_wr_ctl) begin
      mt1_d = wr_data[6];
      mt2_d = wr_data[5];
      st2_d = wr_data[1];
      st1_d = wr_data[0];
    end
    if (tick_80us) p_d = p_q + 1'b1;

    // A rising start bit loads the preset and swallows any coincident tick.
    if (st1_d && !st1_q) begin
      c1_d = t1p_q;
    end else if (st1_d && tick_80us) begin
      if (c1_q == 8'hFF) begin
        c1_d   = t1p_q;
        w_ovf1 = 1'b1;
      end else begin
        c1_d = c1_q + 8'd1;
      end
    end

    if (st2_d && !st2_q) begin
      c2_d = t2p_q;
    end else if (st2_d && w_t2_tick) begin
      if (c2_q == 8'hFF) begin
        c2_d   = t2p_q;
        w_ovf2 = 1'b1;
      end else begin
        c2_d = c2_q + 8'd1;
      end
    end

    // Clear first so a same-cycle overflow still leaves the flag set.
    if (w_wr_rst) begin
      ft1_d = 1'b0;
      ft2_d = 1'b0;
    end
    if (w_ovf1 && !mt1_q) ft1_d = 1'b1;
    if (w_ovf2 && !mt2_q) ft2_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      t1p_q   <= 8'h00;
      t2p_q   <= 8'h00;
      c1_q    <= 8'h00;
      c2_q    <= 8'h00;
      st1_q   <= 1'b0;
      st2_q   <= 1'b0;
      mt1_q   <= 1'b0;
      mt2_q   <= 1'b0;
      ft1_q   <= 1'b0;
      ft2_q   <= 1'b0;
      p_q     <= '0;
      irq_n_q <= 1'b1;
    end else begin
      t1p_q   <= t1p_d;
      t2p_q   <= t2p_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      st1_q   <= st1_d;
      st2_q   <= st2_d;
      mt1_q   <= mt1_d;
      mt2_q   <= mt2_d;
      ft1_q   <= ft1_d;
      ft2_q   <= ft2_d;
      p_q     <= p_d;
      irq_n_q <= ~(ft1_d | ft2_d);
    end
  end

  assign status = {ft1_q | ft2_q, ft1_q, ft2_q, 5'b00000};
  assign irq_n  = irq_n_q;

endmodule

`default_nettype wire

// File: tb/tb_opl3_timers.sv
// ============================================================================
//  Module   : tb_opl3_timers
//  Purpose  : Directed scoreboard bench for opl3_timers.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_opl3_timers;

  logic       clk;
  logic       reset_n;
  logic       tick_80us;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] status;
  logic       irq_n;

  int n_checks;
  int n_fail;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  opl3_timers #(.TIMER2_PRESCALE(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick_80us (tick_80us),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .status    (status),
    .irq_n     (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares the DUT against each queued expectation at negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      if (status !== e) begin
        n_fail++;
        $display("FAIL %s status: got %02h expected %02h", t, status, e);
      end
      n_checks++;
      if (irq_n !== ~e[7]) begin
        n_fail++;
        $display("FAIL %s irq_n: got %b expected %b", t, irq_n, ~e[7]);
      end
    end
  end

  task automatic cyc(input bit wr, input logic [7:0] a, input logic [7:0] d, input bit tk);
    wr_en     = wr;
    wr_addr   = a;
    wr_data   = d;
    tick_80us = tk;
    @(posedge clk);
    #1;
    wr_en     = 1'b0;
    tick_80us = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cyc(1'b1, a, d, 1'b0);
  endtask

  task automatic tick();
    cyc(1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic expect_st(input logic [7:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'h04, 8'h63, 1'b1);
      expect_st(8'h00, "reset_hold");
    end
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    tick_80us = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = 8'h00;
    wr_data   = 8'h00;

    // Reset, then idle ticks with timers stopped
    do_reset();
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (i % 250 == 0) expect_st(8'h00, "idle_stopped");
    end

    // Timer 1 overflow after two ticks from preset FE, then RST clear
    do_reset();
    wr(8'h02, 8'hFE);
    wr(8'h04, 8'h01);
    tick(); expect_st(8'h00, "t1_tick1");
    tick(); expect_st(8'hC0, "t1_ovf");
    wr(8'h04, 8'h80); expect_st(8'h00, "t1_rst_clear");

    // Timer 2: preset FF overflows every 4 ticks
    do_reset();
    wr(8'h03, 8'hFF);
    wr(8'h04, 8'h02);
    for (int i = 1; i <= 3; i++) begin tick(); expect_st(8'h00, "t2_pre"); end
    tick(); expect_st(8'hA0, "t2_ovf1");
    wr(8'h04, 8'h80); expect_st(8'h00, "t2_clear");
    for (int i = 1; i <= 3; i++) begin tick(); expect_st(8'h00, "t2_pre2"); end
    tick(); expect_st(8'hA0, "t2_ovf2");

    // Mask: overflows at 3,6,9 ticks are silent; unmask, flag 3 ticks later
    do_reset();
    wr(8'h02, 8'hFD);
    wr(8'h04, 8'h41);
    for (int i = 1; i <= 9; i++) begin tick(); expect_st(8'h00, "mask_silent"); end
    wr(8'h04, 8'h01); expect_st(8'h00, "unmask");
    tick(); expect_st(8'h00, "unmask_t1");
    tick(); expect_st(8'h00, "unmask_t2");
    tick(); expect_st(8'hC0, "unmask_ovf");

    // Preset change mid-count: 256-tick period completes, then 16-tick period
    do_reset();
    wr(8'h04, 8'h01);
    repeat (100) tick();
    wr(8'h02, 8'hF0);
    repeat (154) tick();
    tick(); expect_st(8'h00, "p0_tick255");
    tick(); expect_st(8'hC0, "p0_tick256");
    wr(8'h04, 8'h81); expect_st(8'h00, "p0_clear");
    repeat (14) tick();
    tick(); expect_st(8'h00, "pF0_tick15");
    tick(); expect_st(8'hC0, "pF0_tick16");

    // Stop freezes, restart reloads the preset
    wr(8'h04, 8'h80); expect_st(8'h00, "ss_clear");
    repeat (5) tick();
    wr(8'h04, 8'h00);
    for (int i = 1; i <= 20; i++) begin tick(); expect_st(8'h00, "stopped"); end
    wr(8'h04, 8'h01);
    for (int i = 1; i <= 15; i++) begin tick(); expect_st(8'h00, "restart_pre"); end
    tick(); expect_st(8'hC0, "restart_ovf");

    // Stopping keeps the flag
    wr(8'h04, 8'h00); expect_st(8'hC0, "stop_keeps_flag");

    // RST write coinciding with overflow: set wins
    do_reset();
    wr(8'h02, 8'hFF);
    wr(8'h04, 8'h01);
    tick(); expect_st(8'hC0, "ff_ovf");
    cyc(1'b1, 8'h04, 8'h80, 1'b1); expect_st(8'hC0, "rst_vs_ovf");
    wr(8'h04, 8'h80); expect_st(8'h00, "rst_alone");

    // Start write with coincident tick: counter holds preset, not preset+1
    do_reset();
    wr(8'h02, 8'hFE);
    cyc(1'b1, 8'h04, 8'h01, 1'b1); expect_st(8'h00, "start_tick");
    tick(); expect_st(8'h00, "start_tick_next");
    tick(); expect_st(8'hC0, "start_tick_ovf");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/opl3_timers.md
Name: opl3_timers

Overview:
- Implements the two OPL3 programmable interval timers: Timer 1 at 80 us resolution and Timer 2 at 320 us resolution.
- Consumes the single-cycle 80 us clock-enable pulse from the clock-divider stage, plus CPU register writes to bank-0 addresses 0x02/0x03/0x04.
- Produces the status-register timer/IRQ bits and an active-low interrupt line for the host interface.

Parameters:
- TIMER2_PRESCALE, 4, number of tick_80us pulses per Timer 2 increment; must be a power of 2, >= 2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- tick_80us  input  1  one-clk enable pulse every 80 us, from the clock divider
- wr_en  input  1  one-clk register write strobe
- wr_addr  input  8  register address, bank 0 only
- wr_data  input  8  register write data
- status  output  8  {IRQ, FT1, FT2, 5'b0}
- irq_n  output  1  ~IRQ, registered

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, reset_n. All state updates on posedge clk.
- Reset (reset_n=0 at a posedge) clears everything:
  - presets T1P, T2P = 0; counters C1, C2 = 0; ST1, ST2, MT1, MT2 = 0
  - prescaler P = 0; FT1, FT2 = 0
  - status = 8'h00; irq_n = 1
  - Reset overrides any write or tick in the same cycle.
- Register writes (wr_en=1; other addresses ignored):
  - 0x02 -> T1P = wr_data.
  - 0x03 -> T2P = wr_data.
  - 0x04, wr_data[7]=1 (RST): clear FT1 and FT2; all other bits of this write are ignored.
  - 0x04, wr_data[7]=0: MT1 = d[6], MT2 = d[5], ST2 = d[1], ST1 = d[0].
- Preset writes never disturb a running counter; the new preset is used at the next load or reload.
- Start/stop:
  - ST 0->1: counter loads its preset on that write cycle.
  - ST 1->1: no reload.
  - ST 1->0: counter freezes at its current value.
- Prescaler P:
  - log2(TIMER2_PRESCALE)-bit counter, free-running from reset, increments on every tick_80us, wraps silently.
  - t2_tick = tick_80us && (P == TIMER2_PRESCALE-1).
- Counting (timer 1 on tick_80us, timer 2 on t2_tick, only while ST=1):
  - If C != 8'hFF: C = C+1.
  - If C == 8'hFF: overflow; C = preset. If M=0, F is set. If M=1, F is not set, but the timer keeps counting and reloading.
- Overflow period is (256 - preset) ticks. Preset 0xFF gives an overflow on every tick.
- A start write and a tick in the same cycle: the load wins, and the tick is lost for that timer.
- Flags:
  - Sticky until an RST write or reset.
  - Setting a mask bit does not clear a flag that is already set.
  - RST write coinciding with an overflow in the same cycle: the set wins, so the flag ends up 1.
- Outputs:
  - status[7] = FT1|FT2; status[6] = FT1; status[5] = FT2; status[4:0] = 0.
  - Latency: the flag and status are visible the cycle after the overflowing tick. irq_n follows status[7] inverted, with no extra stage.
- Stopped timers never set flags. Stopping a timer does not clear its flag.

Test Plan:
- Reset check: hold reset_n=0 for 3 clks, with wr_en and tick_80us active -> status=8'h00, irq_n=1. After release, no flag for 1000 ticks with ST=0.
- Timer 1 overflow: write 0x02=0xFE, then 0x04=0x01, then pulse tick_80us 2 times -> status=8'hC0 and irq_n=0 one clk after the 2nd tick. Then RST write 0x04=0x80 -> status=8'h00, irq_n=1.
- Timer 2 prescale: write 0x03=0xFF, then 0x04=0x02 with P=0 -> FT2 sets after exactly 4 ticks, giving status=8'hA0. The next overflow comes 4 ticks later (after an RST clear).
- Mask: write 0x02=0xFD, then 0x04=0x41 -> no flag after 3, 6 or 9 ticks. Write 0x04=0x01 -> FT1 sets exactly 3 ticks after the last reload.
- Preset change and stop/restart:
  - Running with preset 0x00, write 0x02=0xF0 mid-count -> the current period still completes at 256 ticks; the next period is 16 ticks.
  - ST1 1->0 freezes C1; 0->1 reloads it.
- Simultaneous events:
  - RST write in the same clk as an overflow tick -> FT1=1 afterwards.
  - Start write in the same clk as a tick -> C1 = preset, not preset+1.
